imm_extend_stage: RTL and testbench
===================================

# imm_extend_stage

Registered, parametrised successor to the combinational immediate extender. It sits between decode and the ID/EX register. It accepts a valid/ready stream of instruction words with immediate-type selects and sign- or zero-extends each immediate to XLEN bits. Results are buffered in a 2-entry skid FIFO so decode can be stalled or flushed without losing or duplicating an immediate. A side-band tag (pc, rd, etc.) travels with each entry.

## Interface
- XLEN, 32: output immediate width; legal values 32 or 64.
- TAG_W, 8: width of the pass-through tag carried with each entry.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- flush_i  input  1  discard all buffered entries and any same-cycle input.
- in_valid_i  input  1  input entry valid.
- in_ready_o  output  1  stage can accept an entry this cycle.
- instr_i  input  25  instruction bits [31:7].
- imm_src_i  input  3  immediate type select.
- tag_i  input  TAG_W  side-band tag.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  consumer takes the head entry this cycle.
- imm_ext_o  output  XLEN  extended immediate of the head entry.
- tag_o  output  TAG_W  tag of the head entry.
- err_o  output  1  head entry had an illegal imm_src.

## Operation
- Extension is computed combinationally at the input and stored into the FIFO on acceptance (in_valid_i && in_ready_o).
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - U: sext({instr[31:12], 12'b0}), sign-extended from bit 31 when XLEN=64.
  - CSR (zimm): zero-extended instr[19:15].
- Every sign extension replicates instr[31] up to bit XLEN-1.
- Illegal imm_src (110, 111): the stored immediate is 0 and the stored err bit is 1. This is not sticky; it belongs to that entry only.
- FIFO: 2 entries, count 0..2.
  - in_ready_o = (count != 2). It is combinational from count only, never from out_ready_i.
  - out_valid_o = (count != 0).
  - imm_ext_o, tag_o and err_o present the head entry.
  - Pop when out_valid_o && out_ready_i.
  - Simultaneous push and pop at count 1: count stays 1, and the new entry becomes head next cycle.
- The FSM is implied by count, with states EMPTY(0), ONE(1), FULL(2):
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop. Push is impossible while FULL.
- flush_i: next cycle count = 0. A same-cycle push and pop are both ignored, and flush takes priority over everything except reset.
- Reset, including mid-stream: count = 0. out_valid_o, imm_ext_o, tag_o and err_o are all 0. in_ready_o is 1 during and after reset.
- Outputs of empty slots are don't-care internally, but imm_ext_o, tag_o and err_o are driven 0 whenever out_valid_o = 0.

## Timing
- Latency 1 cycle: an entry accepted in cycle N appears on out_valid_o in cycle N+1 if the FIFO was empty.
- Throughput is 1 entry per cycle with out_ready_i held high.
- With the consumer stalled, 2 entries are absorbed, then in_ready_o drops in the cycle after the second push.
- After a single pop from FULL, in_ready_o rises in the next cycle.
- No combinational path from in_valid_i to out_valid_o, or from out_ready_i to in_ready_o.

## Configuration
- IMM_CSR_EXT_EN defined: the CSR zimm type (imm_src 101) is supported as above.
- IMM_CSR_EXT_EN undefined: 101 is treated as illegal (immediate 0, err 1). The zimm datapath is not synthesised.

## Structure
- The imm_src encodings live in the shared control package, not in this block:
  - I=000, S=001, B=010, J=011, U=100, CSR=101.
- The same package holds the imm_src_t typedef and the localparam for FIFO depth 2.
- One natural sub-module: imm_extend_core, a pure combinational extender parametrised on XLEN. It is instantiated once at the FIFO input.
- The FIFO storage and count logic are kept inline.

## Test plan
- Reset and I-type stream:
  - Stimulus: reset asserted 2 cycles, then instr=25'h1FFFFFF, imm_src=I, with out_ready_i=1.
  - Response: after reset all outputs are 0 and in_ready_o=1. One cycle after the push, imm_ext_o=32'hFFFFFFFF, out_valid_o=1 and err_o=0.
- Per-type vectors:
  - Stimulus: for each of S/B/J/U with XLEN=64, push an entry with instr[31]=1.
  - Response: upper 32 bits all 1. B and J have bit 0 = 0. U has bits [11:0] = 0.
- Backpressure:
  - Stimulus: out_ready_i=0; push tags 1, 2, 3.
  - Response: in_ready_o goes low after tag 2, and tag 3 is not accepted. Then raise out_ready_i.
  - Response: tag_o sequence 1, 2 with no duplication; in_ready_o returns 1.
- Flush priority:
  - Stimulus: at count 2, assert flush_i together with in_valid_i and out_ready_i.
  - Response: next cycle out_valid_o=0, imm_ext_o=0, count=0, and the new entry is dropped.
- CSR and illegal selects:
  - Stimulus: instr[19:15]=5'b11010 with imm_src=101.
  - Response: imm_ext_o=32'h0000001A with the macro defined; 0 with err_o=1 without it. imm_src=111 always gives 0 with err_o=1.
- Mid-stream reset:
  - Stimulus: pull rst_n_i low at count 1, with a simultaneous push.
  - Response: next cycle out_valid_o=0 and all outputs 0; the entry is lost.

Source files
------------

// File: rtl/imm_extend_stage_pkg.sv
// Shared control definitions for the immediate-extend stage: imm_src encodings,
// skid FIFO depth and the FIFO occupancy state type.
package imm_extend_stage_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_CSR  = 3'b101,
        IMM_RSV6 = 3'b110,
        IMM_RSV7 = 3'b111
    } imm_src_t;

    localparam int FIFO_DEPTH = 2;

    // Occupancy doubles as the FSM state: the encoding is the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: builds the 32-bit immediate and sign-extends
// it to XLEN. The CSR zimm path exists only when IMM_CSR_EXT_EN is defined.
module imm_extend_core
    import imm_extend_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr_i,
    input  logic [2:0]      imm_src_i,
    output logic [XLEN-1:0] imm_ext_o,
    output logic            err_o
);

    logic        sign;
    logic [31:0] raw;

    assign sign = instr_i[24];

    // instr_i holds instruction bits [31:7], so instruction bit k is instr_i[k-7].
    always_comb begin
        raw   = '0;
        err_o = 1'b0;
        case (imm_src_t'(imm_src_i))
            IMM_I: raw = {{20{sign}}, instr_i[24:13]};
            IMM_S: raw = {{20{sign}}, instr_i[24:18], instr_i[4:0]};
            IMM_B: raw = {{19{sign}}, instr_i[24], instr_i[0], instr_i[23:18], instr_i[4:1], 1'b0};
            IMM_J: raw = {{11{sign}}, instr_i[24], instr_i[12:5], instr_i[13], instr_i[23:14], 1'b0};
            IMM_U: raw = {instr_i[24:5], 12'b0};
`ifdef IMM_CSR_EXT_EN
            IMM_CSR: raw = {27'b0, instr_i[12:8]};
`endif
            default: begin
                raw   = '0;
                err_o = 1'b1;
            end
        endcase
    end

    // raw[31] already equals the sign (or 0 for zimm), so widening replicates it.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign imm_ext_o = {{32{raw[31]}}, raw};
        end else begin : g_xlen32
            assign imm_ext_o = raw;
        end
    endgenerate

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extend stage with a 2-entry skid FIFO and pass-through tag.
// Optional CSR zimm support is enabled by defining IMM_CSR_EXT_EN.
module imm_extend_stage
    import imm_extend_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [24:0]      instr_i,
    input  logic [2:0]       imm_src_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_ext_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; ready depends only on registered occupancy, never on the other side's valid/ready.

    logic [XLEN-1:0]  new_imm;
    logic             new_err;

    imm_extend_core #(.XLEN(XLEN)) u_core (
        .instr_i   (instr_i),
        .imm_src_i (imm_src_i),
        .imm_ext_o (new_imm),
        .err_o     (new_err)
    );

    fifo_state_t      state_q, state_d;
    logic             push, pop;
    logic             wr_head, wr_tail, shift;

    logic [XLEN-1:0]  imm0_q, imm1_q;
    logic [TAG_W-1:0] tag0_q, tag1_q;
    logic             err0_q, err1_q;

    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot 0 is always the head; slot 1 only ever holds the second entry.
    always_comb begin
        state_d = state_q;
        wr_head = 1'b0;
        wr_tail = 1'b0;
        shift   = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        wr_head = 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            state_d = ST_FULL;
                            wr_tail = 1'b1;
                        end
                        2'b01: state_d = ST_EMPTY;
                        2'b11: wr_head = 1'b1;
                        default: state_d = ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        shift   = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Payload needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_head) begin
            imm0_q <= new_imm;
            tag0_q <= tag_i;
            err0_q <= new_err;
        end else if (shift) begin
            imm0_q <= imm1_q;
            tag0_q <= tag1_q;
            err0_q <= err1_q;
        end
        if (wr_tail) begin
            imm1_q <= new_imm;
            tag1_q <= tag_i;
            err1_q <= new_err;
        end
    end

    assign imm_ext_o   = out_valid_o ? imm0_q : '0;
    assign tag_o       = out_valid_o ? tag0_q : '0;
    assign err_o       = out_valid_o && err0_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed scenarios plus a randomized
// stream, both XLEN=32 and XLEN=64 instances driven from the same inputs.
module tb_imm_extend_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [24:0] instr;
    logic [2:0]  imm_src;
    logic [7:0]  tag;

    logic        rdy32, vld32, err32;
    logic [31:0] imm32;
    logic [7:0]  tag32;
    logic [1:0]  st32;
    logic        rdy64, vld64, err64;
    logic [63:0] imm64;
    logic [7:0]  tag64;
    logic [1:0]  st64;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } ent_t;

    ent_t exp_q[$];

    imm_extend_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy32), .instr_i(instr), .imm_src_i(imm_src), .tag_i(tag),
        .out_valid_o(vld32), .out_ready_i(out_ready), .imm_ext_o(imm32),
        .tag_o(tag32), .err_o(err32), .dbg_state_o(st32)
    );

    imm_extend_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy64), .instr_i(instr), .imm_src_i(imm_src), .tag_i(tag),
        .out_valid_o(vld64), .out_ready_i(out_ready), .imm_ext_o(imm64),
        .tag_o(tag64), .err_o(err64), .dbg_state_o(st64)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: rebuild the full instruction word and sign-extend by signed arithmetic.
    function automatic void ref_imm(input logic [24:0] ins, input logic [2:0] src,
                                    output logic [63:0] val, output logic err);
        logic [31:0] w;
        longint      v;
        w   = {ins, 7'b0};
        v   = 0;
        err = 1'b0;
        case (src)
            3'd0: v = $signed(w[31:20]);
            3'd1: v = $signed({w[31:25], w[11:7]});
            3'd2: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            3'd3: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            3'd4: v = $signed({w[31:12], 12'b0});
`ifdef IMM_CSR_EXT_EN
            3'd5: v = longint'(w[19:15]);
`endif
            default: begin
                v   = 0;
                err = 1'b1;
            end
        endcase
        val = v;
    endfunction

    // Driver: one clock with the model updated from the inputs seen at that edge.
    task automatic tick();
        bit   acc, pp;
        ent_t e;
        acc = in_valid && (exp_q.size() < 2);
        pp  = out_ready && (exp_q.size() > 0);
        ref_imm(instr, imm_src, e.imm, e.err);
        e.tag = tag;
        @(posedge clk);
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic set_idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        imm_src   = 3'd0;
        tag       = '0;
    endtask

    task automatic clear_fifo();
        set_idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_during: got %b/%b want 1", rdy32, rdy64);
        end
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (vld32 !== 1'b0 || vld64 !== 1'b0 || imm32 !== 32'h0 || imm64 !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld %b/%b imm %h/%h want 0", vld32, vld64, imm32, imm64);
        end
        n_checks++;
        if (tag32 !== 8'h0 || err32 !== 1'b0 || err64 !== 1'b0 || st32 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_side: tag %h err %b/%b st %0d want 0", tag32, err32, err64, st32);
        end
        tick();
        n_checks++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1 || vld32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: rdy %b/%b vld %b want 1/1/0", rdy32, rdy64, vld32);
        end
    endtask

    task automatic test_i_type();
        clear_fifo();
        in_valid  = 1'b1;
        instr     = 25'h1FFFFFF;
        imm_src   = 3'd0;
        tag       = 8'hA5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (vld32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || err32 !== 1'b0) begin
            n_fail++;
            $display("FAIL i_type32: vld %b imm %h err %b want 1 ffffffff 0", vld32, imm32, err32);
        end
        n_checks++;
        if (vld64 !== 1'b1 || imm64 !== 64'hFFFFFFFF_FFFFFFFF || tag64 !== 8'hA5) begin
            n_fail++;
            $display("FAIL i_type64: vld %b imm %h tag %h want 1 all-ones a5", vld64, imm64, tag64);
        end
        tick();
        n_checks++;
        if (vld32 !== 1'b0 || imm32 !== 32'h0) begin
            n_fail++;
            $display("FAIL i_type_drain: vld %b imm %h want 0 0", vld32, imm32);
        end
    endtask

    task automatic test_per_type();
        logic [63:0] ev;
        logic        ee;
        for (int t = 1; t <= 4; t++) begin
            clear_fifo();
            in_valid = 1'b1;
            instr    = 25'($urandom);
            instr[24] = 1'b1;
            imm_src  = 3'(t);
            tag      = 8'(t);
            ref_imm(instr, imm_src, ev, ee);
            tick();
            in_valid = 1'b0;
            n_checks++;
            if (imm64 !== ev || imm32 !== ev[31:0] || err64 !== 1'b0) begin
                n_fail++;
                $display("FAIL type%0d_value: got %h/%h want %h", t, imm64, imm32, ev);
            end
            n_checks++;
            if (imm64[63:32] !== 32'hFFFFFFFF) begin
                n_fail++;
                $display("FAIL type%0d_upper: got %h want ffffffff", t, imm64[63:32]);
            end
            if (t == 2 || t == 3) begin
                n_checks++;
                if (imm64[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL type%0d_bit0: got %b want 0", t, imm64[0]);
                end
            end
            if (t == 4) begin
                n_checks++;
                if (imm64[11:0] !== 12'h0) begin
                    n_fail++;
                    $display("FAIL u_low12: got %h want 000", imm64[11:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        clear_fifo();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag       = 8'd1;
        tick();
        n_checks++;
        if (rdy32 !== 1'b1 || tag32 !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_after1: rdy %b tag %0d want 1 1", rdy32, tag32);
        end
        tag = 8'd2;
        tick();
        n_checks++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0 || st32 !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_after2: rdy %b/%b st %0d want 0/0 2", rdy32, rdy64, st32);
        end
        tag = 8'd3;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (st64 !== 2'd2 || tag64 !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_tag3_refused: st %0d head %0d want 2 1", st64, tag64);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (vld32 !== 1'b1 || tag32 !== 8'd2 || rdy32 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: vld %b tag %0d rdy %b want 1 2 1", vld32, tag32, rdy32);
        end
        tick();
        n_checks++;
        if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: vld %b/%b tag %0d want empty", vld32, vld64, tag32);
        end
    endtask

    task automatic test_flush();
        clear_fifo();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 25'h1ABCDEF;
        tick();
        tick();
        n_checks++;
        if (st32 !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_setup: st %0d want 2", st32);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        tag       = 8'h77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (vld32 !== 1'b0 || imm32 !== 32'h0 || imm64 !== 64'h0 || st64 !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_prio: vld %b imm %h/%h st %0d want 0", vld32, imm32, imm64, st64);
        end
        tick();
        n_checks++;
        if (vld64 !== 1'b0 || tag64 !== 8'h0) begin
            n_fail++;
            $display("FAIL flush_dropped: vld %b tag %h want 0 00", vld64, tag64);
        end
    endtask

    task automatic test_csr_illegal();
        logic [63:0] csr_exp;
        logic        csr_err;
`ifdef IMM_CSR_EXT_EN
        csr_exp = 64'h1A;
        csr_err = 1'b0;
`else
        csr_exp = 64'h0;
        csr_err = 1'b1;
`endif
        clear_fifo();
        in_valid = 1'b1;
        instr    = '0;
        instr[12:8] = 5'b11010;
        instr[24] = 1'b1;
        imm_src  = 3'b101;
        tick();
        n_checks++;
        if (imm32 !== csr_exp[31:0] || imm64 !== csr_exp || err32 !== csr_err) begin
            n_fail++;
            $display("FAIL csr_zimm: imm %h/%h err %b want %h err %b", imm32, imm64, err32, csr_exp, csr_err);
        end
        imm_src = 3'b111;
        tick();
        n_checks++;
        if (imm32 !== 32'h0 || imm64 !== 64'h0 || err32 !== 1'b1 || err64 !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_111: imm %h/%h err %b/%b want 0 err 1", imm32, imm64, err32, err64);
        end
        imm_src = 3'b110;
        tick();
        imm_src = 3'b000;
        n_checks++;
        if (imm64 !== 64'h0 || err64 !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_110: imm %h err %b want 0 err 1", imm64, err64);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (err32 !== 1'b0 || err64 !== 1'b0 || imm64 !== 64'hFFFFFFFF_FFFFF800) begin
            n_fail++;
            $display("FAIL err_not_sticky: err %b/%b imm %h want 0 fffffffffffff800", err32, err64, imm64);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        clear_fifo();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        instr     = 25'h1555555;
        tag       = 8'h3C;
        tick();
        n_checks++;
        if (st32 !== 2'd1 || vld32 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_setup: st %0d vld %b want 1 1", st32, vld32);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (vld32 !== 1'b0 || vld64 !== 1'b0 || imm32 !== 32'h0 || tag64 !== 8'h0 || err64 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: vld %b/%b imm %h tag %h want all 0", vld32, vld64, imm32, tag64);
        end
        n_checks++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: rdy %b/%b want 1", rdy32, rdy64);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (vld32 !== 1'b0 || st64 !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset_lost: vld %b st %0d want 0 0", vld32, st64);
        end
    endtask

    // Scoreboard: random traffic compared every cycle against the queue model.
    task automatic test_random_stream();
        ent_t e;
        clear_fifo();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            instr     = 25'($urandom);
            imm_src   = 3'($urandom_range(0, 7));
            tag       = 8'($urandom);
            tick();
            e = (exp_q.size() > 0) ? exp_q[0] : '0;
            n_checks++;
            if (vld32 !== (exp_q.size() != 0) || vld64 !== (exp_q.size() != 0) ||
                rdy32 !== (exp_q.size() != 2) || rdy64 !== (exp_q.size() != 2)) begin
                n_fail++;
                $display("FAIL rand_flags cyc %0d: vld %b/%b rdy %b/%b want count %0d",
                         i, vld32, vld64, rdy32, rdy64, exp_q.size());
            end
            n_checks++;
            if (imm64 !== e.imm || imm32 !== e.imm[31:0] || tag32 !== e.tag || tag64 !== e.tag ||
                err32 !== e.err || err64 !== e.err) begin
                n_fail++;
                $display("FAIL rand_data cyc %0d: imm %h/%h tag %h err %b want imm %h tag %h err %b",
                         i, imm64, imm32, tag64, err64, e.imm, e.tag, e.err);
            end
        end
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_i_type();
        test_per_type();
        test_backpressure();
        test_flush();
        test_csr_illegal();
        test_mid_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
